// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised PRBS source, run-time Fibonacci/Galois selection,
// seed load, all-zero lock-up recovery and optional period measurement.
// Optional feature macro: LFSR_GEN_PERIOD_EN (period counter, o_wrap, o_period).
module lfsr_gen #(
    parameter int unsigned WIDTH = 8,
    parameter logic [31:0] TAPS  = 32'h0000_00B8,
    parameter logic [31:0] SEED  = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_out,
    output logic             o_bit,
    output logic             o_lockup,
    output logic             o_wrap,
    output logic [WIDTH-1:0] o_period
);

    // Fibonacci taps feed the XOR tree; the Galois mask is the same polynomial
    // with the x^WIDTH term dropped and the constant term added.
    localparam logic [WIDTH-1:0] FIB_MASK = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] GAL_MASK = {TAPS[WIDTH-2:0], 1'b1};
    localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             lockup_q;
    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic [WIDTH-1:0] step_next;
    logic             is_zero;
    logic             do_recover;
    logic             do_step;

    // Candidate next states for both structures and the per-cycle action decode.
    always_comb begin
        fib_next   = {r_q[WIDTH-2:0], ^(r_q & FIB_MASK)};
        gal_next   = {r_q[WIDTH-2:0], 1'b0} ^ (r_q[WIDTH-1] ? GAL_MASK : '0);
        step_next  = i_mode ? gal_next : fib_next;
        is_zero    = (r_q == '0);
        do_recover = !i_load && i_en && is_zero;
        do_step    = !i_load && i_en && !is_zero;
    end

    // State register: load beats recovery beats step beats hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q      <= SEED_W;
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= 1'b0;
            if (i_load) begin
                r_q <= i_seed;
            end else if (do_recover) begin
                r_q      <= ONE_W;
                lockup_q <= 1'b1;
            end else if (do_step) begin
                r_q <= step_next;
            end
        end
    end

    assign o_out    = r_q;
    assign o_bit    = r_q[WIDTH-1];
    assign o_lockup = lockup_q;

`ifdef LFSR_GEN_PERIOD_EN
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] period_q;
    logic             wrap_q;
    logic             wrap_hit;

    // A step that lands back on the reference value closes one period.
    always_comb begin
        wrap_hit = do_step && (step_next == ref_q);
    end

    // Reference, step counter and period capture; load/recovery restart the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q    <= SEED_W;
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (i_load) begin
                ref_q <= i_seed;
                cnt_q <= '0;
            end else if (do_recover) begin
                ref_q <= ONE_W;
                cnt_q <= '0;
            end else if (wrap_hit) begin
                wrap_q   <= 1'b1;
                period_q <= cnt_q + ONE_W;
                cnt_q    <= '0;
            end else if (do_step) begin
                cnt_q <= cnt_q + ONE_W;
            end
        end
    end

    assign o_wrap   = wrap_q;
    assign o_period = period_q;
`else
    assign o_wrap   = 1'b0;
    assign o_period = '0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed checks of lfsr_gen at WIDTH=8 (default polynomial)
// and WIDTH=4 (x^4+x^3+1), with or without LFSR_GEN_PERIOD_EN.
module tb_lfsr_gen;

`ifdef LFSR_GEN_PERIOD_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic       clk;
    logic       rst8, en8, load8, mode8;
    logic [7:0] seed8;
    logic [7:0] out8, period8;
    logic       bit8, lockup8, wrap8;

    logic       rst4, en4, load4, mode4;
    logic [3:0] seed4;
    logic [3:0] out4, period4;
    logic       bit4, lockup4, wrap4;

    int n_checks = 0;
    int n_fail   = 0;

    logic       exp_wrap;
    logic [7:0] exp_period8;
    logic [3:0] exp_period4;

    lfsr_gen u8 (
        .clk(clk), .rst(rst8), .i_en(en8), .i_load(load8), .i_seed(seed8),
        .i_mode(mode8), .o_out(out8), .o_bit(bit8), .o_lockup(lockup8),
        .o_wrap(wrap8), .o_period(period8)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(32'h0000_000C), .SEED(32'h0000_0001)) u4 (
        .clk(clk), .rst(rst4), .i_en(en4), .i_load(load4), .i_seed(seed4),
        .i_mode(mode4), .o_out(out4), .o_bit(bit4), .o_lockup(lockup4),
        .o_wrap(wrap4), .o_period(period4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst8 = 1'b0; rst4 = 1'b0;
        en8 = 1'b0; load8 = 1'b0; mode8 = 1'b0; seed8 = 8'h00;
        en4 = 1'b0; load4 = 1'b0; mode4 = 1'b0; seed4 = 4'h0;
        #2;
        rst8 = 1'b1; rst4 = 1'b1;
        #1;
        n_checks++;
        if (out8 !== 8'h01) begin n_fail++; $display("FAIL reset_out8 got %h want 01", out8); end
        n_checks++;
        if (lockup8 !== 1'b0 || wrap8 !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses got lockup=%b wrap=%b want 0 0", lockup8, wrap8);
        end
        n_checks++;
        if (period8 !== 8'h00) begin n_fail++; $display("FAIL reset_period got %h want 00", period8); end
        n_checks++;
        if (out4 !== 4'h1) begin n_fail++; $display("FAIL reset_out4 got %h want 1", out4); end
        tick;
        tick;
        rst8 = 1'b0; rst4 = 1'b0;
        tick;
        tick;
        tick;
        n_checks++;
        if (out8 !== 8'h01 || bit8 !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold got out=%h bit=%b want 01 0", out8, bit8);
        end
    endtask

    task automatic test_fibonacci;
        logic [7:0] fib_exp [0:3];
        int early;
        fib_exp[0] = 8'h02; fib_exp[1] = 8'h04; fib_exp[2] = 8'h08; fib_exp[3] = 8'h11;
        mode8 = 1'b0;
        en8   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_checks++;
            if (out8 !== fib_exp[i]) begin
                n_fail++; $display("FAIL fib_step%0d got %h want %h", i + 1, out8, fib_exp[i]);
            end
        end
        early = 0;
        for (int i = 4; i < 254; i++) begin
            tick;
            if (wrap8 !== 1'b0 || out8 === 8'h01) early++;
        end
        n_checks++;
        if (early !== 0) begin n_fail++; $display("FAIL fib_early_wrap got %0d want 0", early); end
        tick;
        n_checks++;
        if (out8 !== 8'h01) begin n_fail++; $display("FAIL fib_return got %h want 01", out8); end
        n_checks++;
        if (wrap8 !== exp_wrap) begin n_fail++; $display("FAIL fib_wrap got %b want %b", wrap8, exp_wrap); end
        n_checks++;
        if (period8 !== exp_period8) begin
            n_fail++; $display("FAIL fib_period got %0d want %0d", period8, exp_period8);
        end
        en8 = 1'b0;
        tick;
        n_checks++;
        if (wrap8 !== 1'b0 || out8 !== 8'h01) begin
            n_fail++; $display("FAIL fib_wrap_clear got wrap=%b out=%h want 0 01", wrap8, out8);
        end
    endtask

    task automatic test_galois;
        int early;
        mode8 = 1'b1;
        en8   = 1'b0;
        tick;
        n_checks++;
        if (out8 !== 8'h01) begin n_fail++; $display("FAIL gal_mode_switch got %h want 01", out8); end
        load8 = 1'b1; seed8 = 8'h80;
        tick;
        load8 = 1'b0;
        n_checks++;
        if (out8 !== 8'h80 || bit8 !== 1'b1) begin
            n_fail++; $display("FAIL gal_load got out=%h bit=%b want 80 1", out8, bit8);
        end
        en8 = 1'b1;
        tick;
        n_checks++;
        if (out8 !== 8'h71) begin n_fail++; $display("FAIL gal_step1 got %h want 71", out8); end
        tick;
        n_checks++;
        if (out8 !== 8'hE2) begin n_fail++; $display("FAIL gal_step2 got %h want e2", out8); end
        tick;
        n_checks++;
        if (out8 !== 8'hB5) begin n_fail++; $display("FAIL gal_step3 got %h want b5", out8); end
        en8 = 1'b0;
        load8 = 1'b1; seed8 = 8'h01;
        tick;
        load8 = 1'b0;
        en8 = 1'b1;
        early = 0;
        for (int i = 0; i < 254; i++) begin
            tick;
            if (wrap8 !== 1'b0 || out8 === 8'h01) early++;
        end
        n_checks++;
        if (early !== 0) begin n_fail++; $display("FAIL gal_early_wrap got %0d want 0", early); end
        tick;
        n_checks++;
        if (out8 !== 8'h01 || wrap8 !== exp_wrap) begin
            n_fail++; $display("FAIL gal_return got out=%h wrap=%b want 01 %b", out8, wrap8, exp_wrap);
        end
        n_checks++;
        if (period8 !== exp_period8) begin
            n_fail++; $display("FAIL gal_period got %0d want %0d", period8, exp_period8);
        end
        en8 = 1'b0;
    endtask

    task automatic test_zero_seed;
        mode8 = 1'b0;
        load8 = 1'b1; seed8 = 8'h00;
        tick;
        load8 = 1'b0;
        n_checks++;
        if (out8 !== 8'h00 || lockup8 !== 1'b0) begin
            n_fail++; $display("FAIL zero_load got out=%h lockup=%b want 00 0", out8, lockup8);
        end
        tick;
        n_checks++;
        if (out8 !== 8'h00 || lockup8 !== 1'b0) begin
            n_fail++; $display("FAIL zero_hold got out=%h lockup=%b want 00 0", out8, lockup8);
        end
        en8 = 1'b1;
        tick;
        en8 = 1'b0;
        n_checks++;
        if (out8 !== 8'h01 || lockup8 !== 1'b1 || wrap8 !== 1'b0) begin
            n_fail++; $display("FAIL zero_recover got out=%h lockup=%b wrap=%b want 01 1 0", out8, lockup8, wrap8);
        end
        tick;
        n_checks++;
        if (out8 !== 8'h01 || lockup8 !== 1'b0) begin
            n_fail++; $display("FAIL zero_pulse_end got out=%h lockup=%b want 01 0", out8, lockup8);
        end
    endtask

    task automatic test_load_priority;
        int early;
        mode8 = 1'b0;
        en8 = 1'b1; load8 = 1'b1; seed8 = 8'h5A;
        tick;
        load8 = 1'b0;
        n_checks++;
        if (out8 !== 8'h5A || lockup8 !== 1'b0 || wrap8 !== 1'b0) begin
            n_fail++; $display("FAIL load_prio got out=%h lockup=%b wrap=%b want 5a 0 0", out8, lockup8, wrap8);
        end
        early = 0;
        for (int i = 0; i < 254; i++) begin
            tick;
            if (wrap8 !== 1'b0 || out8 === 8'h5A) early++;
        end
        n_checks++;
        if (early !== 0) begin n_fail++; $display("FAIL load_early_wrap got %0d want 0", early); end
        tick;
        n_checks++;
        if (out8 !== 8'h5A || wrap8 !== exp_wrap) begin
            n_fail++; $display("FAIL load_return got out=%h wrap=%b want 5a %b", out8, wrap8, exp_wrap);
        end
        n_checks++;
        if (period8 !== exp_period8) begin
            n_fail++; $display("FAIL load_period got %0d want %0d", period8, exp_period8);
        end
        en8 = 1'b0;
    endtask

    task automatic test_mid_reset_width;
        int early;
        mode4 = 1'b0;
        en4   = 1'b1;
        tick; tick; tick;
        n_checks++;
        if (out4 !== 4'h9) begin n_fail++; $display("FAIL w4_step3 got %h want 9", out4); end
        tick; tick; tick;
        n_checks++;
        if (out4 !== 4'hD || bit4 !== 1'b1) begin
            n_fail++; $display("FAIL w4_step6 got out=%h bit=%b want d 1", out4, bit4);
        end
        rst4 = 1'b1;
        #1;
        n_checks++;
        if (out4 !== 4'h1 || wrap4 !== 1'b0 || lockup4 !== 1'b0) begin
            n_fail++; $display("FAIL w4_async_rst got out=%h wrap=%b lockup=%b want 1 0 0", out4, wrap4, lockup4);
        end
        tick;
        rst4 = 1'b0;
        early = 0;
        for (int i = 0; i < 14; i++) begin
            tick;
            if (wrap4 !== 1'b0 || out4 === 4'h1) early++;
        end
        n_checks++;
        if (early !== 0) begin n_fail++; $display("FAIL w4_early_wrap got %0d want 0", early); end
        tick;
        n_checks++;
        if (out4 !== 4'h1 || wrap4 !== exp_wrap) begin
            n_fail++; $display("FAIL w4_return got out=%h wrap=%b want 1 %b", out4, wrap4, exp_wrap);
        end
        n_checks++;
        if (period4 !== exp_period4) begin
            n_fail++; $display("FAIL w4_period got %0d want %0d", period4, exp_period4);
        end
        en4 = 1'b0;
    endtask

    initial begin
        exp_wrap    = PEN;
        exp_period8 = PEN ? 8'd255 : 8'd0;
        exp_period4 = PEN ? 4'd15 : 4'd0;
        test_reset;
        test_fibonacci;
        test_galois;
        test_zero_seed;
        test_load_priority;
        test_mid_reset_width;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
